// File: rtl/div_ctrl.sv
// Sequencer for the execute-stage multi-cycle divider: latches operands, runs a
// radix-2 restoring division one bit per cycle and stalls F/D/E until done.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] opa_raw;
  logic             sign_q;
  logic             sign_r;
  logic             dbz;

  logic             start_ok;
  logic             last_step;
  logic [WIDTH-1:0] opa_mag;
  logic [WIDTH-1:0] opb_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;

  assign start_ok  = div_start & ~annul;
  assign last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));

  always_comb begin
    opa_mag = (div_signed & opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    opb_mag = (div_signed & opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
  end

  // Partial remainder carries one extra bit so divisors above 2^(WIDTH-1) still compare correctly
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dvsr};
    fits     = ~trial[WIDTH+1];
    rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], fits};
  end

  // Divide-by-zero overrides the sign fix with fixed, deterministic results
  always_comb begin
    if (dbz) begin
      lo_fix = '1;
      hi_fix = opa_raw;
    end else begin
      lo_fix = sign_q ? (~quo_step + 1'b1) : quo_step;
      hi_fix = sign_r ? (~rem_step + 1'b1) : rem_step;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (annul) state_nxt = IDLE;
               else if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    stall_div = resetn & ~annul & (((state == IDLE) & div_start) | (state == RUN));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      quo          <= '0;
      rem          <= '0;
      dvsr         <= '0;
      opa_raw      <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      dbz          <= 1'b0;
      lo           <= '0;
      hi           <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= last_step & ~annul;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            quo     <= opa_mag;
            dvsr    <= opb_mag;
            opa_raw <= opa;
            rem     <= '0;
            count   <= '0;
            sign_q  <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            sign_r  <= div_signed & opa[WIDTH-1];
            dbz     <= (opb == '0);
          end
        end
        RUN: begin
          if (annul) begin
            count <= '0;
          end else begin
            quo   <= quo_step;
            rem   <= rem_step;
            count <= count + CNT_W'(1);
            if (last_step) begin
              lo    <= lo_fix;
              hi    <= hi_fix;
              count <= '0;
            end
          end
        end
        DONE: begin
          count <= '0;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer for the multi-cycle integer divider in the execute stage.
- Latches DIV/DIVU operands when a divide sits in E, then runs a 32-iteration radix-2 restoring division.
- Drives `stall_div` to the hazard unit's `stall_divE` input, freezing F/D/E until the quotient and remainder are ready for the HI/LO write path.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- resetn  input  1  asynchronous active-low reset.
- div_start  input  1  divide instruction valid in E; held high while E is stalled.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE.
- opa  input  WIDTH  dividend (rs value after E forwarding).
- opb  input  WIDTH  divisor (rt value after E forwarding).
- annul  input  1  exception/flush kill of the divide in E.
- stall_div  output  1  combinational; to hazard `stall_divE`.
- result_valid  output  1  registered; high exactly one cycle per completed divide.
- lo  output  WIDTH  quotient, registered, held until next completion.
- hi  output  WIDTH  remainder, registered, held until next completion.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, counter=0, lo=0, hi=0, result_valid=0, internal operand/sign registers cleared. `stall_div` evaluates to 0 in reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - On div_start & ~annul: latch |opa| and |opb| (two's-complement magnitude when div_signed, raw otherwise), latch sign_q = signed & (opa[W-1]^opb[W-1]) and sign_r = signed & opa[W-1], latch divide-by-zero flag (opb==0), clear partial remainder and counter.
  - Next state RUN.
- RUN:
  - One restoring step per cycle: shift {rem, quo} left 1, trial subtract divisor magnitude, keep the result if non-negative and set quotient bit.
  - Counter increments; after the step with counter==WIDTH-1, next state is DONE.
- DONE:
  - lo/hi are loaded on the RUN→DONE edge. Sign fix: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
  - result_valid=1 during DONE. Next state is IDLE unconditionally, even if div_start is still high, because E advances this cycle.
- stall_div = ~annul & ((state==IDLE & div_start) | state==RUN).
  - stall_div is 0 in DONE.
  - Latency: start cycle plus 32 RUN cycles gives 33 stalled cycles; result_valid is asserted in the 34th cycle.
- Divide by zero (architecturally undefined, fixed here for determinism):
  - Full latency is kept.
  - lo = all ones, hi = original opa (raw bits).
  - The sign fix is suppressed.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, a natural wrap with no trap.
- annul in any state:
  - stall_div drops in the same cycle.
  - Next state is IDLE and counter is cleared.
  - result_valid is not asserted, and lo/hi keep their previous values.
  - annul together with div_start in IDLE does not start a divide.
- Operand inputs are ignored outside IDLE; forwarding changes during RUN do not affect the result.
- Back-to-back divides: a second div_start in the cycle after DONE starts normally from IDLE.

Test Plan:
- DIVU opa=100, opb=7, div_start held → stall_div=1 for 33 cycles; result_valid=1 on cycle 34 with lo=14, hi=2; stall_div=0 that cycle.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIV opa=0x80000000, opb=0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 5/0 → lo=0xFFFFFFFF, hi=5, same 33-cycle stall.
- Start DIVU 100/7, assert annul on RUN cycle 10 → stall_div=0 that cycle, no result_valid, lo/hi unchanged; a new DIVU 9/3 then gives lo=3, hi=0 with full latency.
- Deassert resetn asynchronously mid-RUN → all outputs 0 immediately; after release, idle until div_start.
- Two consecutive divides (DIVU 100/7, then DIVU 50/5 with div_start high the cycle after DONE) → two result_valid pulses 34 cycles apart; second gives lo=10, hi=0.
